// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-beat AXI-lite initiator bridging CPU load/store requests to AR/R and AW/W/B handshakes
module axi_lite_master #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_wen_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [DATA_W-1:0]     cpu_wdata_i,
    input  logic [DATA_W/8-1:0]   cpu_wstrb_i,
    output logic                  cpu_busy_o,
    output logic                  cpu_done_o,
    output logic [DATA_W-1:0]     cpu_rdata_o,
    output logic                  cpu_err_o,
    output logic [ADDR_W-1:0]     axi_araddr_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    input  logic [DATA_W-1:0]     axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o,
    output logic [ADDR_W-1:0]     axi_awaddr_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [DATA_W-1:0]     axi_wdata_o,
    output logic [DATA_W/8-1:0]   axi_wstrb_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    input  logic [1:0]            axi_bresp_i,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o
);
    localparam int SW = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_B,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              aw_hs, w_hs;

    assign aw_hs = (state_q == S_WR) && !aw_done_q && axi_awready_i;
    assign w_hs  = (state_q == S_WR) && !w_done_q && axi_wready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    addr_d    = cpu_addr_i;
                    wdata_d   = cpu_wdata_i;
                    wstrb_d   = cpu_wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cpu_wen_i ? S_WR : S_AR;
                end
            end
            S_AR: begin
                if (axi_arready_i) state_d = S_R;
            end
            S_R: begin
                if (axi_rvalid_i) begin
                    rdata_d = axi_rdata_i;
                    err_d   = (axi_rresp_i != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_WR: begin
                // Each channel retires independently; leave once both are retired, counting this cycle's handshakes.
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_B;
            end
            S_B: begin
                if (axi_bvalid_i) begin
                    err_d   = (axi_bresp_i != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign cpu_busy_o    = (state_q != S_IDLE);
    assign cpu_done_o    = (state_q == S_DONE);
    assign cpu_rdata_o   = rdata_q;
    assign cpu_err_o     = err_q;
    assign axi_araddr_o  = addr_q;
    assign axi_arvalid_o = (state_q == S_AR);
    assign axi_rready_o  = (state_q == S_R);
    assign axi_awaddr_o  = addr_q;
    assign axi_awvalid_o = (state_q == S_WR) && !aw_done_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_wvalid_o  = (state_q == S_WR) && !w_done_q;
    assign axi_bready_o  = (state_q == S_B);

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - randomized bench for axi_lite_master against a per-transaction timing model
module tb_axi_lite_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_i, cpu_wen_i;
    logic [63:0] cpu_addr_i, cpu_wdata_i;
    logic [7:0]  cpu_wstrb_i;
    logic        cpu_busy_o, cpu_done_o, cpu_err_o;
    logic [63:0] cpu_rdata_o;
    logic [63:0] axi_araddr_o, axi_awaddr_o, axi_wdata_o, axi_rdata_i;
    logic        axi_arvalid_o, axi_arready_i, axi_rvalid_i, axi_rready_o;
    logic        axi_awvalid_o, axi_awready_i, axi_wvalid_o, axi_wready_i;
    logic        axi_bvalid_i, axi_bready_o;
    logic [1:0]  axi_rresp_i, axi_bresp_i;
    logic [7:0]  axi_wstrb_o;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_wen_i(cpu_wen_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_wstrb_i(cpu_wstrb_i),
        .cpu_busy_o(cpu_busy_o), .cpu_done_o(cpu_done_o),
        .cpu_rdata_o(cpu_rdata_o), .cpu_err_o(cpu_err_o),
        .axi_araddr_o(axi_araddr_o), .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i), .axi_rvalid_i(axi_rvalid_i),
        .axi_rready_o(axi_rready_o),
        .axi_awaddr_o(axi_awaddr_o), .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
        .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wvalid_o(axi_wvalid_o),
        .axi_wready_i(axi_wready_i),
        .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o)
    );

    typedef struct {
        bit          wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          a, r, x, y, b;
    } plan_t;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int cur_k = 0;
    int done_seen = 0;
    int last_done_k = -1;

    logic        exp_busy, exp_done, exp_err;
    logic        exp_arvalid, exp_rready, exp_awvalid, exp_wvalid, exp_bready;
    logic [63:0] exp_rdata, exp_addr, exp_wdata;
    logic [7:0]  exp_wstrb;
    logic [63:0] rdata_m;
    logic        err_m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at t=%0t k=%0d: got %0h expected %0h", nm, $time, cur_k, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",    64'(cpu_busy_o),    64'(exp_busy));
            chk("done",    64'(cpu_done_o),    64'(exp_done));
            chk("err",     64'(cpu_err_o),     64'(exp_err));
            chk("rdata",   cpu_rdata_o,        exp_rdata);
            chk("arvalid", 64'(axi_arvalid_o), 64'(exp_arvalid));
            chk("rready",  64'(axi_rready_o),  64'(exp_rready));
            chk("awvalid", 64'(axi_awvalid_o), 64'(exp_awvalid));
            chk("wvalid",  64'(axi_wvalid_o),  64'(exp_wvalid));
            chk("bready",  64'(axi_bready_o),  64'(exp_bready));
            if (exp_arvalid) chk("araddr", axi_araddr_o, exp_addr);
            if (exp_awvalid) chk("awaddr", axi_awaddr_o, exp_addr);
            if (exp_wvalid) begin
                chk("wdata", axi_wdata_o, exp_wdata);
                chk("wstrb", 64'(axi_wstrb_o), 64'(exp_wstrb));
            end
            if (cpu_done_o === 1'b1) begin
                done_seen++;
                last_done_k = cur_k;
            end
        end
    end

    function automatic int max2(input int p, input int q);
        return (p > q) ? p : q;
    endfunction

    // Completion cycle counted from the acceptance edge: one cycle per address/data phase,
    // one for response, one for the done pulse, plus every wait cycle the slave inserts.
    function automatic int done_cycle(input plan_t p);
        return p.wen ? (3 + max2(p.x, p.y) + p.b) : (3 + p.a + p.r);
    endfunction

    task automatic set_idle();
        exp_busy = 0; exp_done = 0; exp_arvalid = 0; exp_rready = 0;
        exp_awvalid = 0; exp_wvalid = 0; exp_bready = 0;
        exp_rdata = rdata_m; exp_err = err_m;
        axi_arready_i = 0; axi_rvalid_i = 0; axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0;
        axi_rdata_i = {$urandom, $urandom}; axi_rresp_i = 2'($urandom); axi_bresp_i = 2'($urandom);
    endtask

    task automatic set_cycle(input plan_t p, input int k);
        int dk;
        int m;
        dk = done_cycle(p);
        m = max2(p.x, p.y);
        set_idle();
        exp_busy = (k <= dk);
        exp_done = (k == dk);
        exp_addr = p.addr; exp_wdata = p.wdata; exp_wstrb = p.wstrb;
        if (!p.wen) begin
            exp_arvalid   = (k <= 1 + p.a);
            axi_arready_i = (k == 1 + p.a);
            exp_rready    = (k >= 2 + p.a) && (k <= 2 + p.a + p.r);
            axi_rvalid_i  = (k == 2 + p.a + p.r);
            if (axi_rvalid_i) begin
                axi_rdata_i = p.rdata;
                axi_rresp_i = p.resp;
            end
        end else begin
            exp_awvalid   = (k <= 1 + p.x);
            axi_awready_i = (k == 1 + p.x);
            exp_wvalid    = (k <= 1 + p.y);
            axi_wready_i  = (k == 1 + p.y);
            exp_bready    = (k >= 2 + m) && (k <= 2 + m + p.b);
            axi_bvalid_i  = (k == 2 + m + p.b);
            if (axi_bvalid_i) axi_bresp_i = p.resp;
        end
        if (k == dk) begin
            if (!p.wen) rdata_m = p.rdata;
            err_m = (p.resp != 2'b00);
        end
        exp_rdata = rdata_m;
        exp_err   = err_m;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_cpu(input bit hold_req);
        cpu_req_i   = hold_req ? 1'b1 : 1'($urandom);
        cpu_wen_i   = 1'($urandom);
        cpu_addr_i  = {$urandom, $urandom};
        cpu_wdata_i = {$urandom, $urandom};
        cpu_wstrb_i = 8'($urandom);
    endtask

    task automatic run_txn(input plan_t p, input bit hold_req);
        int d0;
        int dk;
        d0 = done_seen;
        dk = done_cycle(p);
        cur_k = 0;
        set_idle();
        cpu_req_i = 1'b1; cpu_wen_i = p.wen; cpu_addr_i = p.addr;
        cpu_wdata_i = p.wdata; cpu_wstrb_i = p.wstrb;
        step();
        for (int k = 1; k <= dk; k++) begin
            cur_k = k;
            set_cycle(p, k);
            noise_cpu(hold_req);
            step();
        end
        chk("done_count", 64'(done_seen - d0), 64'd1);
        chk("done_cycle", 64'(last_done_k), 64'(dk));
    endtask

    task automatic idle_cycle();
        cur_k = 0;
        set_idle();
        cpu_req_i = 1'b0;
        cpu_wen_i = 1'($urandom);
        cpu_addr_i = {$urandom, $urandom};
        step();
    endtask

    function automatic plan_t rand_plan();
        plan_t p;
        p.wen   = 1'($urandom);
        p.addr  = {$urandom, $urandom};
        p.wdata = {$urandom, $urandom};
        p.wstrb = 8'($urandom);
        p.rdata = {$urandom, $urandom};
        p.resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        p.a = $urandom_range(0, 3); p.r = $urandom_range(0, 3);
        p.x = $urandom_range(0, 3); p.y = $urandom_range(0, 3);
        p.b = $urandom_range(0, 3);
        return p;
    endfunction

    function automatic plan_t mk(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] wstrb, input logic [63:0] rdata, input logic [1:0] resp,
                                 input int a, input int r, input int x, input int y, input int b);
        plan_t p;
        p.wen = wen; p.addr = addr; p.wdata = wdata; p.wstrb = wstrb; p.rdata = rdata; p.resp = resp;
        p.a = a; p.r = r; p.x = x; p.y = y; p.b = b;
        return p;
    endfunction

    initial begin
        plan_t p;
        int d0;
        rdata_m = '0;
        err_m = 1'b0;
        rst = 1'b1;
        cpu_req_i = 0; cpu_wen_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_wstrb_i = '0;
        set_idle();
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        idle_cycle();

        run_txn(mk(0, 64'h80000010, 64'h0, 8'h0, 64'h1122334455667788, 2'b00, 0, 0, 0, 0, 0), 1'b0);
        chk("pin_read_done_k", 64'(last_done_k), 64'd3);
        chk("pin_read_rdata", cpu_rdata_o, 64'h1122334455667788);
        chk("pin_read_err", 64'(cpu_err_o), 64'd0);

        run_txn(mk(1, 64'h80000008, 64'hDEADBEEF, 8'h0F, 64'h0, 2'b00, 0, 0, 2, 0, 0), 1'b0);
        chk("pin_w_before_aw_done_k", 64'(last_done_k), 64'd5);
        chk("pin_write_keeps_rdata", cpu_rdata_o, 64'h1122334455667788);

        run_txn(mk(0, 64'h80000010, 64'h0, 8'h0, 64'hCAFEF00D12345678, 2'b00, 3, 2, 0, 0, 0), 1'b0);
        chk("pin_read_bp_done_k", 64'(last_done_k), 64'd8);

        run_txn(mk(1, 64'h80000020, 64'h55AA, 8'hFF, 64'h0, 2'b10, 0, 0, 1, 1, 1), 1'b0);
        chk("pin_bresp_err", 64'(cpu_err_o), 64'd1);
        run_txn(mk(0, 64'h80000028, 64'h0, 8'h0, 64'h0123456789ABCDEF, 2'b00, 0, 1, 0, 0, 0), 1'b0);
        chk("pin_read_clears_err", 64'(cpu_err_o), 64'd0);

        // Abort a write while both AW and W are still pending.
        p = mk(1, 64'h80000040, 64'h77, 8'h01, 64'h0, 2'b00, 0, 0, 5, 5, 0);
        d0 = done_seen;
        cur_k = 0; set_idle();
        cpu_req_i = 1; cpu_wen_i = 1; cpu_addr_i = p.addr; cpu_wdata_i = p.wdata; cpu_wstrb_i = p.wstrb;
        step();
        cur_k = 1; set_cycle(p, 1); noise_cpu(1'b0); step();
        cur_k = 2; set_cycle(p, 2); noise_cpu(1'b0); rst = 1'b1; step();
        rdata_m = '0; err_m = 1'b0;
        cur_k = 0; set_idle(); cpu_req_i = 0; step();
        rst = 1'b0;
        chk("pin_reset_no_done", 64'(done_seen - d0), 64'd0);
        chk("pin_reset_rdata", cpu_rdata_o, 64'd0);
        run_txn(mk(1, 64'h80000048, 64'h99, 8'hF0, 64'h0, 2'b00, 1, 0, 0, 1, 2), 1'b0);

        for (int i = 0; i < 20; i++) run_txn(rand_plan(), 1'b1);
        for (int i = 0; i < 300; i++) begin
            run_txn(rand_plan(), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
